// File: rtl/instruction_memory.sv
// instruction_memory: backing store behind the instruction cache refill port.
// Serves one 16-byte line per request as four 32-bit beats after a fixed
// access latency; a word-wide loader port preloads the program image.
module instruction_memory #(
  parameter int MEM_BYTES_LOG2 = 10,
  parameter int LATENCY        = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_beat,
  output logic        resp_last,
  input  logic        ld_we,
  input  logic [63:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int WORDS  = 1 << (MEM_BYTES_LOG2 - 2);
  localparam int LINE_W = MEM_BYTES_LOG2 - 4;
  localparam int WAIT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_t;

  logic [31:0] mem [WORDS];

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [1:0]          beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          rbeat_q, rbeat_d;
  logic                last_q, last_d;
  logic                load;
  logic [1:0]          rd_beat;

  // Address bits outside the store window and below word/line granularity.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[63:MEM_BYTES_LOG2], req_addr[3:0],
                              ld_addr[63:MEM_BYTES_LOG2], ld_addr[1:0]};

  // Loader writes; contents survive RESET so a preloaded image stays put.
  // NOTE: the word array has no reset branch on purpose - clearing a RAM
  // would force it into flops and would also wipe the loaded program.
  always_ff @(posedge CLK) begin
    if (!RESET && ld_we) begin
      mem[ld_addr[MEM_BYTES_LOG2-1:2]] <= ld_data;
    end
  end

  // Next-state and registered-output logic for the request/burst FSM.
  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    ready_d = ready_q;
    valid_d = valid_q;
    data_d  = data_q;
    rbeat_d = rbeat_q;
    last_d  = last_q;
    load    = 1'b0;
    rd_beat = beat_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          line_d  = req_addr[MEM_BYTES_LOG2-1:4];
          beat_d  = 2'd0;
          wait_d  = WAIT_W'(LATENCY);
          state_d = (LATENCY > 0) ? S_WAIT : S_BURST;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - WAIT_W'(1);
        if (wait_q <= WAIT_W'(1)) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (!valid_q) begin
          // First beat: loaded on the edge after entering the burst.
          load = 1'b1;
        end else if (resp_ready) begin
          if (beat_q == 2'd3) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            rd_beat = beat_q + 2'd1;
            load    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Data is sampled at the loading edge, so a same-edge loader write
    // to that word is not seen by this beat.
    if (load) begin
      data_d  = mem[{line_q, rd_beat}];
      valid_d = 1'b1;
      rbeat_d = rd_beat;
      last_d  = (rd_beat == 2'd3);
    end
  end

  // State and output registers with synchronous reset.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      beat_q  <= 2'd0;
      wait_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      rbeat_q <= 2'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      rbeat_q <= rbeat_d;
      last_q  <= last_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign resp_beat  = rbeat_q;
  assign resp_last  = last_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_instruction_memory;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        sel = 1'b0;          // 0: LATENCY=3 instance, 1: LATENCY=0
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = '0;
  logic        resp_ready = 1'b1;
  logic        ld_we = 1'b0;
  logic [63:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  always #5 CLK = ~CLK;

  logic        rq_rdy_a, rv_a, rl_a, rq_rdy_b, rv_b, rl_b;
  logic [31:0] rd_a, rd_b;
  logic [1:0]  rb_a, rb_b;
  logic        req_valid_a, req_valid_b;

  assign req_valid_a = req_valid && !sel;
  assign req_valid_b = req_valid && sel;

  instruction_memory #(.MEM_BYTES_LOG2(10), .LATENCY(3)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid_a), .req_ready(rq_rdy_a), .req_addr(req_addr),
    .resp_valid(rv_a), .resp_ready(resp_ready), .resp_data(rd_a),
    .resp_beat(rb_a), .resp_last(rl_a),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  instruction_memory #(.MEM_BYTES_LOG2(10), .LATENCY(0)) u_dut_l0 (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid_b), .req_ready(rq_rdy_b), .req_addr(req_addr),
    .resp_valid(rv_b), .resp_ready(resp_ready), .resp_data(rd_b),
    .resp_beat(rb_b), .resp_last(rl_b),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  logic        cur_req_ready, cur_valid, cur_last;
  logic [31:0] cur_data;
  logic [1:0]  cur_beat;
  assign cur_req_ready = sel ? rq_rdy_b : rq_rdy_a;
  assign cur_valid     = sel ? rv_b : rv_a;
  assign cur_data      = sel ? rd_b : rd_a;
  assign cur_beat      = sel ? rb_b : rb_a;
  assign cur_last      = sel ? rl_b : rl_a;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  b;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   exp_first = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency of the first beat, stall stability, beat scoreboard.
  logic        prev_valid = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  prev_beat = '0;
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET) begin
      if (cur_valid && !prev_valid && exp_first >= 0) begin
        check("first_beat_cycle", 64'(cyc), 64'(exp_first));
        exp_first = -1;
      end
      if (prev_stall && cur_valid)
        check("stall_hold", {cur_data, cur_beat}, {prev_data, prev_beat});
      if (cur_valid && resp_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got data %h beat %0d, none expected", cur_data, cur_beat);
        end else begin
          e = sb.pop_front();
          check("beat", {cur_data, cur_beat, cur_last}, {e.d, e.b, e.b == 2'd3});
        end
      end
    end
    prev_valid = cur_valid;
    prev_stall = cur_valid && !resp_ready;
    prev_data  = cur_data;
    prev_beat  = cur_beat;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] d);
    ld_we = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic do_req(input logic [63:0] a, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
    bit ok = 0;
    int lat = sel ? 0 : 3;
    sb.push_back('{w0, 2'd0});
    sb.push_back('{w1, 2'd1});
    sb.push_back('{w2, 2'd2});
    sb.push_back('{w3, 2'd3});
    req_valid = 1'b1;
    req_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (cur_req_ready) begin
        exp_first = cyc + 2 + lat;
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL req_accept_timeout: addr %h never accepted", a);
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0 && !cur_valid) break;
      step();
    end
    check({name, "_drain"}, 64'(sb.size()), 64'd0);
    check({name, "_req_ready_after"}, 64'(cur_req_ready), 64'd1);
  endtask

  task automatic wait_beat(input logic [1:0] b);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (cur_valid && cur_beat == b) begin
        ok = 1;
        break;
      end
      step();
    end
    check("wait_beat_seen", 64'(ok), 64'd1);
  endtask

  initial begin
    automatic logic [6:0] pat = 7'b1101001;  // bit i applies on cycle i: 1,0,0,1,0,1,1

    repeat (3) step();
    check("rst_req_ready", 64'(cur_req_ready), 64'd0);
    check("rst_outputs", {cur_valid, cur_data, cur_beat, cur_last}, 64'd0);
    RESET = 1'b0;
    step();
    check("req_ready_after_reset", 64'(cur_req_ready), 64'd1);

    load(64'h0, 32'h0050_0093);
    load(64'h4, 32'hFFDF_F06F);
    load(64'h8, 32'h0);
    load(64'hC, 32'h0);
    load(64'h10, 32'hDEAD_BEEF);
    load(64'h14, 32'h1111_1111);
    load(64'h18, 32'h2222_2222);
    load(64'h1C, 32'h3333_3333);
    load(64'h20, 32'hA0A0_A0A0);
    load(64'h24, 32'hA1A1_A1A1);
    load(64'h28, 32'hA2A2_A2A2);
    load(64'h2C, 32'hA3A3_A3A3);

    // Basic fill, resp_ready held high.
    do_req(64'h4, 32'h0050_0093, 32'hFFDF_F06F, 32'h0, 32'h0);
    wait_done("basic");

    // Same fill with back-pressure.
    resp_ready = 1'b0;
    do_req(64'h4, 32'h0050_0093, 32'hFFDF_F06F, 32'h0, 32'h0);
    wait_beat(2'd0);
    for (int i = 0; i < 7; i++) begin
      resp_ready = pat[i];
      step();
    end
    resp_ready = 1'b1;
    wait_done("stall");

    // Address wraps modulo store size.
    do_req(64'h410, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    wait_done("wrap");

    // Second request held while busy.
    do_req(64'h0, 32'h0050_0093, 32'hFFDF_F06F, 32'h0, 32'h0);
    req_valid = 1'b1;
    req_addr = 64'h10;
    for (int i = 0; i < 6; i++) begin
      step();
      check("busy_req_ready", 64'(cur_req_ready), 64'd0);
    end
    do_req(64'h10, 32'hDEAD_BEEF, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    wait_done("held_req");

    // Reset during beat 1 aborts the burst; memory survives.
    do_req(64'h0, 32'h0050_0093, 32'hFFDF_F06F, 32'h0, 32'h0);
    wait_beat(2'd1);
    resp_ready = 1'b0;
    RESET = 1'b1;
    step();
    sb.delete();
    check("abort_req_ready", 64'(cur_req_ready), 64'd0);
    check("abort_outputs", {cur_valid, cur_data, cur_beat, cur_last}, 64'd0);
    RESET = 1'b0;
    resp_ready = 1'b1;
    step();
    check("abort_req_ready_back", 64'(cur_req_ready), 64'd1);
    do_req(64'h0, 32'h0050_0093, 32'hFFDF_F06F, 32'h0, 32'h0);
    wait_done("refill");

    // LATENCY=0 with a loader write to word 2 while beat 0 is presented.
    sel = 1'b1;
    step();
    do_req(64'h20, 32'hA0A0_A0A0, 32'hA1A1_A1A1, 32'hCAFE_F00D, 32'hA3A3_A3A3);
    step();
    check("l0_beat0_present", {cur_valid, cur_beat}, {1'b1, 2'd0});
    load(64'h28, 32'hCAFE_F00D);
    wait_done("lat0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
